// File: rtl/minority_voter_pkg.sv
// Shared constants and helpers for the windowed minority/majority voter.
package minority_voter_pkg;

  localparam logic MODE_MINORITY = 1'b0;
  localparam logic MODE_MAJORITY = 1'b1;

  // Widest sample popcount() can count; callers zero-extend narrower vectors.
  localparam int MAX_BITS = 64;

  function automatic int unsigned popcount(input logic [MAX_BITS-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < MAX_BITS; i++) c = c + {31'b0, v[i]};
    return c;
  endfunction

  // Window decision with hysteresis: an exact tie keeps the previous output.
  function automatic logic win_decide(input int unsigned sum, input int unsigned win,
                                      input logic prev);
    if (2 * sum > win) return 1'b1;
    if (2 * sum < win) return 1'b0;
    return prev;
  endfunction

endpackage

// File: rtl/minority_voter_win_if.sv
// Sample input and vote result bundle between the sensor front end and the voter.
interface minority_voter_win_if #(
  parameter int N   = 5,
  parameter int WIN = 4,
  parameter int CW  = $clog2(N + 1),
  parameter int SW  = $clog2(WIN + 1)
);

  // Handshake: strobe-only, no ready. A cycle with in_valid=1 is a sample that
  // is always consumed; vote_valid/out_valid are one-cycle result strobes that
  // the consumer must take on that cycle.
  logic          in_valid;
  logic [N-1:0]  in_bits;
  logic          mode;
  logic          clear;
  logic [CW-1:0] ones_cnt;
  logic          vote;
  logic          vote_valid;
  logic [SW-1:0] win_sum;
  logic          win_out;
  logic          win_full;
  logic          out_valid;

  modport master (
    output in_valid, in_bits, mode, clear,
    input  ones_cnt, vote, vote_valid, win_sum, win_out, win_full, out_valid
  );

  modport slave (
    input  in_valid, in_bits, mode, clear,
    output ones_cnt, vote, vote_valid, win_sum, win_out, win_full, out_valid
  );

endinterface

// File: rtl/vote_window.sv
// Sliding window over the last WIN votes: shift register, running sum, fill flag
// and hysteresis decision.
module vote_window
  import minority_voter_pkg::*;
#(
  parameter int WIN = 4,
  parameter int SW  = $clog2(WIN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  input  logic          in_vote,
  output logic [SW-1:0] sum,
  output logic          decision,
  output logic          full,
  output logic          out_valid
);

  localparam int unsigned WIN_U = WIN;

  logic [WIN-1:0] win_q;
  logic [SW-1:0]  fill_q;
  logic [SW-1:0]  sum_q;
  logic           full_q;
  logic           dec_q;
  logic           ov_q;

  logic           evicted;
  logic [SW-1:0]  sum_next;
  logic           full_next;
  logic           dec_next;

  always_comb begin
    evicted   = full_q & win_q[WIN-1];
    sum_next  = sum_q + SW'(in_vote) - SW'(evicted);
    full_next = full_q | (fill_q == SW'(WIN - 1));
    dec_next  = dec_q;
    if (full_next) dec_next = win_decide(32'(sum_next), WIN_U, dec_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q  <= '0;
      fill_q <= '0;
      sum_q  <= '0;
      full_q <= 1'b0;
      dec_q  <= 1'b0;
      ov_q   <= 1'b0;
    end else if (clear) begin
      win_q  <= '0;
      fill_q <= '0;
      sum_q  <= '0;
      full_q <= 1'b0;
      dec_q  <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      ov_q <= in_valid;
      if (in_valid) begin
        win_q  <= {win_q[WIN-2:0], in_vote};
        sum_q  <= sum_next;
        full_q <= full_next;
        dec_q  <= dec_next;
        if (!full_q) fill_q <= fill_q + 1'b1;
      end
    end
  end

  // The running sum counts only bits held in the window, so it can never exceed WIN.
  always @(posedge clk) begin
    if (rst_n) assert (sum_q <= SW'(WIN));
  end

  assign sum       = sum_q;
  assign decision  = dec_q;
  assign full      = full_q;
  assign out_valid = ov_q;

endmodule

// File: rtl/minority_voter_win.sv
// Registered per-sample minority/majority vote feeding a sliding-window debouncer.
module minority_voter_win
  import minority_voter_pkg::*;
#(
  parameter int N   = 5,
  parameter int WIN = 4,
  parameter int CW  = $clog2(N + 1),
  parameter int SW  = $clog2(WIN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  minority_voter_win_if.slave bus
);

  localparam int unsigned N_U = N;

  if ((N % 2) == 0 || N > MAX_BITS) begin : g_bad_n
    $error("minority_voter_win: N must be odd and at most 64");
  end
  if (WIN < 2 || WIN > 64) begin : g_bad_win
    $error("minority_voter_win: WIN must lie in 2..64");
  end

  int unsigned   ones;
  logic          vote_d;
  logic [CW-1:0] ones_q;
  logic          vote_q;
  logic          vv_q;

  always_comb begin
    ones   = popcount(MAX_BITS'(bus.in_bits));
    vote_d = (2 * ones < N_U);
    if (bus.mode == MODE_MAJORITY) vote_d = (2 * ones > N_U);
  end

  // clear kills the strobe of a sample arriving with it, but vote/ones_cnt keep
  // their last accepted values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q <= '0;
      vote_q <= 1'b0;
      vv_q   <= 1'b0;
    end else if (bus.clear) begin
      vv_q <= 1'b0;
    end else begin
      vv_q <= bus.in_valid;
      if (bus.in_valid) begin
        ones_q <= CW'(ones);
        vote_q <= vote_d;
      end
    end
  end

  assign bus.ones_cnt   = ones_q;
  assign bus.vote       = vote_q;
  assign bus.vote_valid = vv_q;

  vote_window #(.WIN(WIN), .SW(SW)) u_window (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (bus.clear),
    .in_valid  (vv_q),
    .in_vote   (vote_q),
    .sum       (bus.win_sum),
    .decision  (bus.win_out),
    .full      (bus.win_full),
    .out_valid (bus.out_valid)
  );

endmodule
